// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot decoder with enable, direct-decode mode and a
// prescaled up/down ring scanner with load and wrap pulse.
module decoder_scan_n #(
    parameter int SEL_W    = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    E,
    input  logic [1:0]              MODE,
    input  logic [SEL_W-1:0]        A,
    input  logic                    LOAD,
    output logic [(2**SEL_W)-1:0]   D,
    output logic [SEL_W-1:0]        IDX,
    output logic                    WRAP
);

    localparam int OUT_W = 2**SEL_W;
    localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};
    localparam logic [OUT_W-1:0] ONE_HOT0 = {{(OUT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    mode_e             mode_r;
    logic [PS_W-1:0]   ps_r;
    logic [SEL_W-1:0]  idx_r;
    logic [OUT_W-1:0]  d_r;
    logic              wrap_r;

    logic              mode_chg_s;
    logic [PS_W-1:0]   ps_nxt_s;
    logic [SEL_W-1:0]  idx_nxt_s;
    logic [OUT_W-1:0]  d_nxt_s;
    logic              wrap_nxt_s;

    // Next-state selection: enable gating, mode-change restart, load, prescaled step.
    always_comb begin
        mode_chg_s = (MODE != mode_r);
        idx_nxt_s  = idx_r;
        ps_nxt_s   = ps_r;
        wrap_nxt_s = 1'b0;
        if (E) begin
            case (MODE)
                MODE_DIRECT: begin
                    idx_nxt_s = A;
                    ps_nxt_s  = {PS_W{1'b0}};
                end
                MODE_UP, MODE_DOWN: begin
                    if (LOAD) begin
                        idx_nxt_s = A;
                        ps_nxt_s  = {PS_W{1'b0}};
                    end else if (mode_chg_s) begin
                        ps_nxt_s = {PS_W{1'b0}};
                    end else if (ps_r == PS_LAST) begin
                        ps_nxt_s = {PS_W{1'b0}};
                        if (MODE == MODE_UP) begin
                            idx_nxt_s  = idx_r + SEL_W'(1);
                            wrap_nxt_s = (idx_r == IDX_MAX);
                        end else begin
                            idx_nxt_s  = idx_r - SEL_W'(1);
                            wrap_nxt_s = (idx_r == {SEL_W{1'b0}});
                        end
                    end else begin
                        ps_nxt_s = ps_r + PS_W'(1);
                    end
                end
                MODE_HOLD: begin
                    if (mode_chg_s) begin
                        ps_nxt_s = {PS_W{1'b0}};
                    end else begin
                        ps_nxt_s = ps_r;
                    end
                end
                default: begin
                    idx_nxt_s = idx_r;
                    ps_nxt_s  = ps_r;
                end
            endcase
        end else begin
            idx_nxt_s = idx_r;
            ps_nxt_s  = ps_r;
        end
        // D is derived from the next index so D and IDX never skew.
        if (E) begin
            d_nxt_s = ONE_HOT0 << idx_nxt_s;
        end else begin
            d_nxt_s = {OUT_W{1'b0}};
        end
    end

    // State and output registers; the previous mode tracks MODE even while disabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_r <= MODE_DIRECT;
            ps_r   <= {PS_W{1'b0}};
            idx_r  <= {SEL_W{1'b0}};
            d_r    <= {OUT_W{1'b0}};
            wrap_r <= 1'b0;
        end else begin
            mode_r <= mode_e'(MODE);
            ps_r   <= ps_nxt_s;
            idx_r  <= idx_nxt_s;
            d_r    <= d_nxt_s;
            wrap_r <= wrap_nxt_s;
        end
    end

    assign D    = d_r;
    assign IDX  = idx_r;
    assign WRAP = wrap_r;

endmodule
